// File: rtl/kfmmc_command_sequencer.sv
// Command/response sequencer between the KFMMC register front-end and the byte-level
// MMC link engine. All state, including the link-engine controls, moves on the falling clock edge.
module kfmmc_command_sequencer #(
    parameter int unsigned CMD_BYTES      = 6,
    parameter int unsigned MAX_RESP_BYTES = 17,
    parameter int unsigned TIMEOUT_WIDTH  = 16
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                start_command,
    input  logic                                abort,
    input  logic [CMD_BYTES*8-1:0]              command,
    input  logic                                enable_command_crc,
    input  logic                                enable_response_crc,
    input  logic [$clog2(MAX_RESP_BYTES+1)-1:0] response_length,
    input  logic [TIMEOUT_WIDTH-1:0]            timeout_cycles,
    output logic                                command_busy,
    output logic                                command_done,
    output logic [MAX_RESP_BYTES*8-1:0]         response,
    output logic                                response_error,
    output logic                                response_timeout,
    output logic                                start_communication_to_mmc,
    output logic                                command_io_to_mmc,
    output logic                                check_command_start_bit_to_mmc,
    output logic                                clear_command_crc_to_mmc,
    output logic                                clear_command_interrupt_to_mmc,
    output logic                                mask_command_interrupt_to_mmc,
    output logic                                set_send_command_to_mmc,
    output logic [7:0]                          send_command_to_mmc,
    input  logic [7:0]                          received_response_from_mmc,
    input  logic [6:0]                          send_command_crc_from_mmc,
    input  logic [6:0]                          received_response_crc_from_mmc,
    input  logic                                mmc_is_in_connecting,
    input  logic                                sent_command_interrupt_from_mmc,
    input  logic                                received_response_interrupt_from_mmc
);
    localparam int unsigned CMD_W  = CMD_BYTES * 8;
    localparam int unsigned RESP_W = MAX_RESP_BYTES * 8;
    localparam int unsigned LEN_W  = $clog2(MAX_RESP_BYTES + 1);
    localparam int unsigned IDX_W  = $clog2(CMD_BYTES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_START, ST_RECV} state_t;
    state_t state_q, state_d;

    logic [CMD_W-1:0]         cmd_q, cmd_d;
    logic                     cmd_crc_en_q, cmd_crc_en_d, resp_crc_en_q, resp_crc_en_d;
    logic [LEN_W-1:0]         remaining_q, remaining_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d, tmo_cnt_inc;
    logic [7:0]               crc_cap_q, crc_cap_d;
    logic [RESP_W-1:0]        resp_d;
    logic                     busy_d, done_d, err_d, tmo_d, start_d, io_d, chk_d;
    logic                     clr_crc_d, clr_int_d, mask_d, set_send_d;
    logic [7:0]               send_byte_d, tx_byte_c;
    logic                     issue_first_c, sent_more_c, sent_last_c, rx_c, rx_last_c, tmo_hit_c;

    // Protocol events seen this cycle, and the byte to transmit for the current send index
    always_comb begin
        tmo_cnt_inc   = tmo_cnt_q + TIMEOUT_WIDTH'(1);
        issue_first_c = (state_q == ST_SEND) && (idx_q == '0) && !mmc_is_in_connecting;
        sent_more_c   = (state_q == ST_SEND) && (idx_q != '0) && (idx_q < IDX_W'(CMD_BYTES))
                        && sent_command_interrupt_from_mmc;
        sent_last_c   = (state_q == ST_SEND) && (idx_q == IDX_W'(CMD_BYTES))
                        && sent_command_interrupt_from_mmc;
        rx_c          = ((state_q == ST_WAIT_START) || (state_q == ST_RECV))
                        && received_response_interrupt_from_mmc;
        rx_last_c     = rx_c && (remaining_q <= LEN_W'(1));
        tmo_hit_c     = (state_q == ST_WAIT_START) && !rx_c && (timeout_cycles != '0)
                        && (tmo_cnt_inc == timeout_cycles);
        tx_byte_c = 8'hFF;
        for (int unsigned i = 0; i < CMD_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) tx_byte_c = cmd_q[CMD_W-8-8*i +: 8];
        end
        if (cmd_crc_en_q && (idx_q == IDX_W'(CMD_BYTES - 1)))
            tx_byte_c = {send_command_crc_from_mmc, 1'b1};
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:       if (start_command) state_d = ST_SEND;
                ST_SEND:       if (sent_last_c)
                                   state_d = (remaining_q == '0) ? ST_IDLE : ST_WAIT_START;
                ST_WAIT_START: if (rx_c)           state_d = rx_last_c ? ST_IDLE : ST_RECV;
                               else if (tmo_hit_c) state_d = ST_IDLE;
                ST_RECV:       if (rx_last_c)      state_d = ST_IDLE;
                default:       state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of the datapath and the registered link-engine controls
    always_comb begin
        cmd_d         = cmd_q;
        cmd_crc_en_d  = cmd_crc_en_q;
        resp_crc_en_d = resp_crc_en_q;
        remaining_d   = remaining_q;
        idx_d         = idx_q;
        tmo_cnt_d     = tmo_cnt_q;
        crc_cap_d     = crc_cap_q;
        resp_d        = response;
        err_d         = response_error;
        tmo_d         = response_timeout;
        start_d       = 1'b0;
        chk_d         = 1'b0;
        clr_crc_d     = 1'b0;
        clr_int_d     = 1'b0;
        set_send_d    = 1'b0;
        send_byte_d   = send_command_to_mmc;
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_q != ST_IDLE) && (state_d == ST_IDLE);
        mask_d        = (state_d == ST_IDLE);
        io_d          = (state_d != ST_SEND);
        if (!abort) begin
            case (state_q)
                ST_IDLE: if (start_command) begin
                    cmd_d         = command;
                    cmd_crc_en_d  = enable_command_crc;
                    resp_crc_en_d = enable_response_crc;
                    remaining_d   = (response_length > LEN_W'(MAX_RESP_BYTES))
                                    ? LEN_W'(MAX_RESP_BYTES) : response_length;
                    idx_d         = '0;
                    crc_cap_d     = 8'h00;
                    resp_d        = '1;
                    err_d         = 1'b0;
                    tmo_d         = 1'b0;
                end
                ST_SEND: begin
                    if (issue_first_c || sent_more_c) begin
                        start_d     = 1'b1;
                        set_send_d  = 1'b1;
                        clr_int_d   = 1'b1;
                        clr_crc_d   = issue_first_c;
                        send_byte_d = tx_byte_c;
                        idx_d       = idx_q + IDX_W'(1);
                    end else if (sent_last_c && (remaining_q != '0)) begin
                        start_d   = 1'b1;
                        chk_d     = 1'b1;
                        clr_crc_d = 1'b1;
                        tmo_cnt_d = '0;
                    end
                end
                ST_WAIT_START, ST_RECV: begin
                    if (state_q == ST_WAIT_START) tmo_cnt_d = tmo_cnt_inc;
                    if (rx_c) begin
                        resp_d      = {response[RESP_W-9:0], received_response_from_mmc};
                        remaining_d = remaining_q - LEN_W'(1);
                        if (!rx_last_c) begin
                            start_d   = 1'b1;
                            clr_int_d = 1'b1;
                            if (resp_crc_en_q) crc_cap_d = {received_response_crc_from_mmc, 1'b1};
                        end else begin
                            err_d = resp_crc_en_q && (crc_cap_q != received_response_from_mmc);
                        end
                    end else if (tmo_hit_c) begin
                        tmo_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (state_d == ST_IDLE) send_byte_d = 8'hFF;
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q                          <= '0;
            cmd_crc_en_q                   <= 1'b0;
            resp_crc_en_q                  <= 1'b0;
            remaining_q                    <= '0;
            idx_q                          <= '0;
            tmo_cnt_q                      <= '0;
            crc_cap_q                      <= 8'h00;
            response                       <= '1;
            response_error                 <= 1'b0;
            response_timeout               <= 1'b0;
            command_busy                   <= 1'b0;
            command_done                   <= 1'b0;
            start_communication_to_mmc     <= 1'b0;
            command_io_to_mmc              <= 1'b1;
            check_command_start_bit_to_mmc <= 1'b0;
            clear_command_crc_to_mmc       <= 1'b0;
            clear_command_interrupt_to_mmc <= 1'b0;
            mask_command_interrupt_to_mmc  <= 1'b1;
            set_send_command_to_mmc        <= 1'b0;
            send_command_to_mmc            <= 8'hFF;
        end else begin
            cmd_q                          <= cmd_d;
            cmd_crc_en_q                   <= cmd_crc_en_d;
            resp_crc_en_q                  <= resp_crc_en_d;
            remaining_q                    <= remaining_d;
            idx_q                          <= idx_d;
            tmo_cnt_q                      <= tmo_cnt_d;
            crc_cap_q                      <= crc_cap_d;
            response                       <= resp_d;
            response_error                 <= err_d;
            response_timeout               <= tmo_d;
            command_busy                   <= busy_d;
            command_done                   <= done_d;
            start_communication_to_mmc     <= start_d;
            command_io_to_mmc              <= io_d;
            check_command_start_bit_to_mmc <= chk_d;
            clear_command_crc_to_mmc       <= clr_crc_d;
            clear_command_interrupt_to_mmc <= clr_int_d;
            mask_command_interrupt_to_mmc  <= mask_d;
            set_send_command_to_mmc        <= set_send_d;
            send_command_to_mmc            <= send_byte_d;
        end
    end
endmodule

// File: tb/tb_kfmmc_command_sequencer.sv
// Bench for kfmmc_command_sequencer: plays the link engine and checks each transaction
// against a byte-list model of the command/response protocol.
module tb_kfmmc_command_sequencer;
    localparam int unsigned CMD_BYTES      = 6;
    localparam int unsigned MAX_RESP_BYTES = 17;
    localparam int unsigned TIMEOUT_WIDTH  = 16;
    localparam int unsigned CMD_W          = CMD_BYTES * 8;
    localparam int unsigned RESP_W         = MAX_RESP_BYTES * 8;
    localparam int unsigned LEN_W          = $clog2(MAX_RESP_BYTES + 1);

    logic                     clock = 1'b0;
    logic                     reset_n;
    logic                     start_command, abort, enable_command_crc, enable_response_crc;
    logic [CMD_W-1:0]         command;
    logic [LEN_W-1:0]         response_length;
    logic [TIMEOUT_WIDTH-1:0] timeout_cycles;
    logic                     command_busy, command_done, response_error, response_timeout;
    logic [RESP_W-1:0]        response;
    logic                     start_communication_to_mmc, command_io_to_mmc;
    logic                     check_command_start_bit_to_mmc, clear_command_crc_to_mmc;
    logic                     clear_command_interrupt_to_mmc, mask_command_interrupt_to_mmc;
    logic                     set_send_command_to_mmc;
    logic [7:0]               send_command_to_mmc, received_response_from_mmc;
    logic [6:0]               send_command_crc_from_mmc, received_response_crc_from_mmc;
    logic                     mmc_is_in_connecting, sent_command_interrupt_from_mmc;
    logic                     received_response_interrupt_from_mmc;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] dir_b[$];
    logic [6:0] dir_c[$];
    logic [63:0] r64;
    int unsigned rlen, rtmo;

    kfmmc_command_sequencer #(
        .CMD_BYTES(CMD_BYTES), .MAX_RESP_BYTES(MAX_RESP_BYTES), .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start_command(start_command), .abort(abort),
        .command(command), .enable_command_crc(enable_command_crc),
        .enable_response_crc(enable_response_crc), .response_length(response_length),
        .timeout_cycles(timeout_cycles), .command_busy(command_busy), .command_done(command_done),
        .response(response), .response_error(response_error), .response_timeout(response_timeout),
        .start_communication_to_mmc(start_communication_to_mmc),
        .command_io_to_mmc(command_io_to_mmc),
        .check_command_start_bit_to_mmc(check_command_start_bit_to_mmc),
        .clear_command_crc_to_mmc(clear_command_crc_to_mmc),
        .clear_command_interrupt_to_mmc(clear_command_interrupt_to_mmc),
        .mask_command_interrupt_to_mmc(mask_command_interrupt_to_mmc),
        .set_send_command_to_mmc(set_send_command_to_mmc),
        .send_command_to_mmc(send_command_to_mmc),
        .received_response_from_mmc(received_response_from_mmc),
        .send_command_crc_from_mmc(send_command_crc_from_mmc),
        .received_response_crc_from_mmc(received_response_crc_from_mmc),
        .mmc_is_in_connecting(mmc_is_in_connecting),
        .sent_command_interrupt_from_mmc(sent_command_interrupt_from_mmc),
        .received_response_interrupt_from_mmc(received_response_interrupt_from_mmc)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [RESP_W-1:0] obs, input logic [RESP_W-1:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // DUT state moves on negedge; outputs are sampled and inputs driven on posedge
    task automatic tick();
        @(posedge clock);
    endtask

    function automatic logic [7:0] exp_tx(input logic [CMD_W-1:0] c, input bit en,
                                          input logic [6:0] crc, input int unsigned i);
        if (en && (i == CMD_BYTES - 1)) return {crc, 1'b1};
        return 8'(c >> (8 * (CMD_BYTES - 1 - i)));
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_start"}, start_communication_to_mmc, 1'b0);
        chk({tag, "_chk"}, check_command_start_bit_to_mmc, 1'b0);
        chk({tag, "_clrcrc"}, clear_command_crc_to_mmc, 1'b0);
        chk({tag, "_clrint"}, clear_command_interrupt_to_mmc, 1'b0);
        chk({tag, "_setsend"}, set_send_command_to_mmc, 1'b0);
        chk({tag, "_done"}, command_done, 1'b0);
        chk({tag, "_err"}, response_error, 1'b0);
        chk({tag, "_tmo"}, response_timeout, 1'b0);
        chk({tag, "_busy"}, command_busy, 1'b0);
        chk({tag, "_io"}, command_io_to_mmc, 1'b1);
        chk({tag, "_mask"}, mask_command_interrupt_to_mmc, 1'b1);
        chk({tag, "_txbyte"}, send_command_to_mmc, 8'hFF);
        chk({tag, "_resp"}, response, {RESP_W{1'b1}});
    endtask

    task automatic run_txn(input logic [CMD_W-1:0] cmd, input bit ccrc, input bit rcrc,
                           input int unsigned len_req, input int unsigned tmo,
                           input logic [6:0] scrc, input bit no_reply,
                           input int unsigned abort_after, input bit poke_start);
        int unsigned eff_len, conn, gap;
        logic [RESP_W-1:0] exp_resp;
        logic [7:0] cap, b;
        logic [6:0] rc;
        bit exp_err;
        eff_len = (len_req > MAX_RESP_BYTES) ? MAX_RESP_BYTES : len_req;
        command = cmd;
        enable_command_crc = ccrc;
        enable_response_crc = rcrc;
        response_length = LEN_W'(len_req);
        timeout_cycles = TIMEOUT_WIDTH'(tmo);
        send_command_crc_from_mmc = scrc;
        conn = $urandom_range(0, 3);
        mmc_is_in_connecting = (conn != 0);
        start_command = 1'b1;
        tick();
        start_command = 1'b0;
        chk("busy_on_start", command_busy, 1'b1);
        chk("mask_when_busy", mask_command_interrupt_to_mmc, 1'b0);
        chk("resp_preset", response, {RESP_W{1'b1}});
        chk("err_cleared", response_error, 1'b0);
        chk("tmo_cleared", response_timeout, 1'b0);
        for (int unsigned i = 0; i < conn; i++) begin
            tick();
            chk("hold_while_connecting", set_send_command_to_mmc, 1'b0);
        end
        mmc_is_in_connecting = 1'b0;
        tick();
        for (int unsigned i = 0; i < CMD_BYTES; i++) begin
            if (i != 0) begin
                sent_command_interrupt_from_mmc = 1'b1;
                start_command = poke_start && (i == 2);
                tick();
                sent_command_interrupt_from_mmc = 1'b0;
                start_command = 1'b0;
            end
            chk("set_send_pulse", set_send_command_to_mmc, 1'b1);
            chk("start_with_byte", start_communication_to_mmc, 1'b1);
            chk("clr_int_with_byte", clear_command_interrupt_to_mmc, 1'b1);
            chk("clr_crc_first_only", clear_command_crc_to_mmc, (i == 0));
            chk("io_low_in_send", command_io_to_mmc, 1'b0);
            chk("tx_byte", send_command_to_mmc, exp_tx(cmd, ccrc, scrc, i));
            gap = $urandom_range(1, 3);
            for (int unsigned g = 0; g < gap; g++) begin
                tick();
                chk("set_send_one_clock", set_send_command_to_mmc, 1'b0);
                chk("start_one_clock", start_communication_to_mmc, 1'b0);
            end
        end
        sent_command_interrupt_from_mmc = 1'b1;
        tick();
        sent_command_interrupt_from_mmc = 1'b0;
        if (eff_len == 0) begin
            chk("done_no_resp", command_done, 1'b1);
            chk("busy_low_no_resp", command_busy, 1'b0);
            chk("no_check_start", check_command_start_bit_to_mmc, 1'b0);
            chk("mask_idle", mask_command_interrupt_to_mmc, 1'b1);
            tick();
            chk("done_one_clock", command_done, 1'b0);
            return;
        end
        chk("ws_start", start_communication_to_mmc, 1'b1);
        chk("ws_check_start", check_command_start_bit_to_mmc, 1'b1);
        chk("ws_clr_crc", clear_command_crc_to_mmc, 1'b1);
        chk("ws_io_high", command_io_to_mmc, 1'b1);
        chk("ws_done_low", command_done, 1'b0);
        if (no_reply) begin
            if (tmo != 0) begin
                for (int unsigned k = 1; k < tmo; k++) begin
                    tick();
                    chk("no_early_timeout", command_done, 1'b0);
                end
                tick();
                chk("timeout_done", command_done, 1'b1);
                chk("timeout_flag", response_timeout, 1'b1);
                chk("timeout_busy", command_busy, 1'b0);
                chk("timeout_err", response_error, 1'b0);
            end else begin
                repeat (100) tick();
                chk("no_timeout_busy", command_busy, 1'b1);
                chk("no_timeout_flag", response_timeout, 1'b0);
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("abort_wait_done", command_done, 1'b1);
                chk("abort_wait_busy", command_busy, 1'b0);
            end
            tick();
            chk("done_one_clock", command_done, 1'b0);
            return;
        end
        exp_resp = '1;
        cap = 8'h00;
        for (int unsigned j = 0; j < eff_len; j++) begin
            gap = (j == 0) ? $urandom_range(0, 3) : $urandom_range(0, 2);
            for (int unsigned g = 0; g < gap; g++) begin
                tick();
                chk("no_spurious_start", start_communication_to_mmc, 1'b0);
            end
            if (dir_b.size() != 0) begin
                b = dir_b[j];
                rc = dir_c[j];
            end else begin
                b = 8'($urandom);
                rc = 7'($urandom);
                if ((j == eff_len - 1) && rcrc && ($urandom_range(0, 1) == 1)) b = cap;
            end
            received_response_from_mmc = b;
            received_response_crc_from_mmc = rc;
            received_response_interrupt_from_mmc = 1'b1;
            tick();
            received_response_interrupt_from_mmc = 1'b0;
            exp_resp = (exp_resp << 8) | RESP_W'(b);
            if (j + 1 < eff_len) begin
                chk("rx_start", start_communication_to_mmc, 1'b1);
                chk("rx_clr_int", clear_command_interrupt_to_mmc, 1'b1);
                chk("rx_io_high", command_io_to_mmc, 1'b1);
                chk("rx_busy", command_busy, 1'b1);
                if (rcrc) cap = {rc, 1'b1};
                if ((abort_after != 0) && (j + 1 == abort_after)) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    chk("abort_done", command_done, 1'b1);
                    chk("abort_busy", command_busy, 1'b0);
                    chk("abort_resp_hold", response, exp_resp);
                    chk("abort_start", start_communication_to_mmc, 1'b0);
                    chk("abort_mask", mask_command_interrupt_to_mmc, 1'b1);
                    chk("abort_io", command_io_to_mmc, 1'b1);
                    chk("abort_txbyte", send_command_to_mmc, 8'hFF);
                    chk("abort_err", response_error, 1'b0);
                    tick();
                    chk("done_one_clock", command_done, 1'b0);
                    return;
                end
            end else begin
                exp_err = rcrc && (cap != b);
                chk("end_done", command_done, 1'b1);
                chk("end_busy", command_busy, 1'b0);
                chk("end_response", response, exp_resp);
                chk("end_crc_error", response_error, exp_err);
                chk("end_timeout", response_timeout, 1'b0);
                chk("end_no_start", start_communication_to_mmc, 1'b0);
            end
        end
        tick();
        chk("done_one_clock", command_done, 1'b0);
    endtask

    initial begin
        start_command = 1'b0; abort = 1'b0; command = '0;
        enable_command_crc = 1'b0; enable_response_crc = 1'b0;
        response_length = '0; timeout_cycles = '0;
        received_response_from_mmc = 8'h00; send_command_crc_from_mmc = 7'h00;
        received_response_crc_from_mmc = 7'h00; mmc_is_in_connecting = 1'b0;
        sent_command_interrupt_from_mmc = 1'b0; received_response_interrupt_from_mmc = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1 check_reset("por");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_reset("idle_after_reset");

        // CMD0 without CRC and no response, with a stray start while busy
        run_txn(48'h400000000095, 1'b0, 1'b0, 0, 0, 7'h00, 1'b0, 0, 1'b1);
        // Command CRC substitutes the last byte
        run_txn(48'h400000000000, 1'b1, 1'b0, 0, 0, 7'h4A, 1'b0, 0, 1'b0);
        // R1 with matching then mismatching CRC
        dir_b = {8'h11, 8'h00, 8'h00, 8'h09, 8'h00, 8'h25};
        dir_c = {7'h3C, 7'h05, 7'h7F, 7'h00, 7'h12, 7'h00};
        run_txn(48'h510000000001, 1'b1, 1'b1, 6, 0, 7'h33, 1'b0, 0, 1'b0);
        dir_b = {8'h11, 8'h00, 8'h00, 8'h09, 8'h00, 8'h24};
        run_txn(48'h510000000001, 1'b1, 1'b1, 6, 30, 7'h33, 1'b0, 0, 1'b0);
        dir_b.delete();
        dir_c.delete();
        // Start-bit timeout, then indefinite wait when the limit is zero
        run_txn(48'h4D1234000000, 1'b0, 1'b0, 6, 10, 7'h00, 1'b1, 0, 1'b0);
        run_txn(48'h4D1234000000, 1'b0, 1'b0, 6, 0, 7'h00, 1'b1, 0, 1'b0);
        // R2 full length and an over-long request that clamps
        run_txn(48'h420000000000, 1'b1, 1'b1, 17, 25, 7'h4D, 1'b0, 0, 1'b0);
        run_txn(48'h420000000000, 1'b0, 1'b0, 20, 0, 7'h4D, 1'b0, 0, 1'b0);
        // Single-byte response compares against the zero capture
        run_txn(48'h4C0000000000, 1'b0, 1'b1, 1, 0, 7'h00, 1'b0, 0, 1'b0);
        // Abort in RECV after three bytes
        run_txn(48'h4A0000000000, 1'b0, 1'b0, 6, 0, 7'h00, 1'b0, 3, 1'b0);

        // start together with abort in IDLE: nothing starts
        start_command = 1'b1;
        abort = 1'b1;
        tick();
        start_command = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", command_busy, 1'b0);
        chk("start_abort_done", command_done, 1'b0);
        tick();
        chk("start_abort_no_send", set_send_command_to_mmc, 1'b0);

        for (int t = 0; t < 20; t++) begin
            r64 = {$urandom, $urandom};
            rlen = $urandom_range(0, 20);
            rtmo = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(8, 40);
            run_txn(CMD_W'(r64), 1'($urandom), 1'($urandom), rlen, rtmo, 7'($urandom),
                    ($urandom_range(0, 5) == 0), 0, 1'b0);
        end

        // Asynchronous reset in the middle of SEND
        command = 48'h777777777777;
        start_command = 1'b1;
        tick();
        start_command = 1'b0;
        tick();
        chk("pre_reset_pulse", set_send_command_to_mmc, 1'b1);
        tick();
        #2 reset_n = 1'b0;
        #1 check_reset("mid_send_reset");
        tick();
        reset_n = 1'b1;
        tick();
        check_reset("after_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
